// File: rtl/mmi64_upstream_arbiter.sv
// Purpose: round-robin merge of N_REQ message streams onto one upstream beat port.
// Latency: one IDLE arbitration cycle per message, then beats pass combinationally owner -> upstream.
// Backpressure: up_ready_i is routed straight to the owner's req_ready_o; non-owners always see 0.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   req_valid_i/_data_i/_last_i, req_ready_o   per-requester beat handshake (requester k data at [k*DATA_W +: DATA_W])
//   up_valid_o/_data_o/_last_o, up_ready_i     upstream beat handshake
//   grant_o                   one-hot current owner, zero when idle
//   err_overlong_o            one-cycle pulse after a message was cut at MAX_BEATS
module mmi64_upstream_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    up_valid_o,
  output logic [DATA_W-1:0]       up_data_o,
  output logic                    up_last_o,
  input  logic                    up_ready_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    err_overlong_o
);

  // A single requester still needs a 1-bit index.
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand;
  logic             forced_last;

  // First valid requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!pick_vld && req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // The beat on the bus is the last one this message may carry.
  assign forced_last = (cnt_q == CNT_W'(MAX_BEATS - 1));

  // Upstream side mirrors the owner; everything is held at zero while idle.
  always_comb begin
    up_valid_o  = 1'b0;
    up_data_o   = '0;
    up_last_o   = 1'b0;
    req_ready_o = '0;
    if (state_q == BUSY) begin
      up_valid_o  = req_valid_i[owner_q];
      up_data_o   = req_data_i[int'(owner_q)*DATA_W +: DATA_W];
      up_last_o   = req_last_i[owner_q] | forced_last;
      req_ready_o = grant_q & {N_REQ{up_ready_i}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= BUSY;
            grant_q <= N_REQ'(1) << pick_idx;
            owner_q <= pick_idx;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          // Owner keeps the grant across valid gaps until its last beat moves.
          if (up_valid_o && up_ready_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (up_last_o) begin
              state_q <= IDLE;
              grant_q <= '0;
              ptr_q   <= (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
              // Cut short only if the requester itself did not mark this beat last.
              err_q   <= forced_last & ~req_last_i[owner_q];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o        = grant_q;
  assign err_overlong_o = err_q;

endmodule

// File: tb/tb_mmi64_upstream_arbiter.sv
`timescale 1ns/1ps
module tb_mmi64_upstream_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MB = 16;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_last_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            up_valid_o;
  logic [DW-1:0]   up_data_o;
  logic            up_last_o;
  logic            up_ready_i = 1'b1;
  logic [N-1:0]    grant_o;
  logic            err_overlong_o;

  beat_t        bq [N][$];     // beats each requester still has to send
  beat_t        sb_q [N][$];   // scoreboard copy for the randomized run
  logic [N-1:0] xfer_s = '0;
  int           ur_mode = 0;   // 0: ready held 1, 1: random ready, 2: task drives ready
  bit           gap_mode = 1'b0;
  int           total = 0;
  int           bad = 0;

  mmi64_upstream_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_last_i    (req_last_i),
    .req_ready_o   (req_ready_o),
    .up_valid_o    (up_valid_o),
    .up_data_o     (up_data_o),
    .up_last_o     (up_last_o),
    .up_ready_i    (up_ready_i),
    .grant_o       (grant_o),
    .err_overlong_o(err_overlong_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Handshakes seen before the edge decide which requester queues advance.
  initial forever begin
    @(negedge clk_i);
    xfer_s = req_valid_i & req_ready_o;
  end

  // Requester driver: present queue heads shortly after each rising edge.
  initial forever begin
    @(posedge clk_i);
    #1;
    for (int k = 0; k < N; k++) begin
      if (xfer_s[k] && bq[k].size() > 0) void'(bq[k].pop_front());
      if (bq[k].size() > 0 && !(gap_mode && $urandom_range(0, 3) == 0)) begin
        req_valid_i[k]         = 1'b1;
        req_data_i[k*DW +: DW] = bq[k][0].dat;
        req_last_i[k]          = bq[k][0].last;
      end else begin
        req_valid_i[k]         = 1'b0;
        req_data_i[k*DW +: DW] = '0;
        req_last_i[k]          = 1'b0;
      end
    end
    if (ur_mode == 0) up_ready_i = 1'b1;
    else if (ur_mode == 1) up_ready_i = 1'($urandom_range(0, 1));
  end

  function automatic beat_t mk(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.dat  = d;
    b.last = l;
    return b;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic apply_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    for (int k = 0; k < N; k++) bq[k].delete();
    ur_mode  = 0;
    gap_mode = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    bq[0].push_back(mk(64'h1111, 1'b1));
    rst_n_i = 1'b0;
    #1;
    total++;
    if (grant_o !== '0 || up_valid_o !== 1'b0 || req_ready_o !== '0 || err_overlong_o !== 1'b0 || up_data_o !== '0) begin
      bad++;
      $display("FAIL reset_async grant=%b valid=%b ready=%b err=%b (all must be 0)", grant_o, up_valid_o, req_ready_o, err_overlong_o);
    end
    repeat (3) @(negedge clk_i);
    total++;
    if (grant_o !== '0 || up_valid_o !== 1'b0 || req_ready_o !== '0) begin
      bad++;
      $display("FAIL reset_hold grant=%b valid=%b ready=%b with req0 valid (all must be 0)", grant_o, up_valid_o, req_ready_o);
    end
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (grant_o !== '0) begin
      bad++;
      $display("FAIL reset_release grant=%b before first edge, expected 0000", grant_o);
    end
    @(negedge clk_i);
    total++;
    if (grant_o !== 4'b0001 || up_data_o !== 64'h1111 || up_last_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant grant=%b data=%h last=%b, expected 0001/1111/1", grant_o, up_data_o, up_last_o);
    end
    @(negedge clk_i);
    total++;
    if (grant_o !== '0) begin
      bad++;
      $display("FAIL reset_back_idle grant=%b, expected 0000", grant_o);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] d [3];
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    logic          ev;
    logic          el;
    for (int i = 0; i < 3; i++) d[i] = rnd64();
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) bq[2].push_back(mk(d[i], i == 2));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      ev = (c >= 1 && c <= 3);
      eg = ev ? 4'b0100 : 4'b0000;
      el = (c == 3);
      ed = '0;
      if (ev) ed = d[c-1];
      total++;
      if (grant_o !== eg || up_valid_o !== ev || req_ready_o !== eg || err_overlong_o !== 1'b0) begin
        bad++;
        $display("FAIL single_ctrl c%0d grant=%b/%b valid=%b/%b ready=%b/%b err=%b/0", c, grant_o, eg, up_valid_o, ev, req_ready_o, eg, err_overlong_o);
      end
      if (ev) begin
        total++;
        if (up_data_o !== ed || up_last_o !== el) begin
          bad++;
          $display("FAIL single_beat c%0d data=%h/%h last=%b/%b", c, up_data_o, ed, up_last_o, el);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    int            o;
    apply_reset();
    @(negedge clk_i);
    for (int k = 0; k < N; k++)
      for (int m = 0; m < 2; m++) bq[k].push_back(mk(DW'(k*16 + m + 1), 1'b1));
    for (int c = 0; c < 17; c++) begin
      @(negedge clk_i);
      eg = '0;
      ed = '0;
      if (c % 2 == 1) begin
        o      = ((c - 1) / 2) % N;
        eg[o]  = 1'b1;
        ed     = DW'(o*16 + (c - 1) / 8 + 1);
      end
      total++;
      if (grant_o !== eg || up_valid_o !== (eg != '0)) begin
        bad++;
        $display("FAIL rr_grant c%0d grant=%b/%b valid=%b", c, grant_o, eg, up_valid_o);
      end
      if (eg != '0) begin
        total++;
        if (up_data_o !== ed || up_last_o !== 1'b1) begin
          bad++;
          $display("FAIL rr_beat c%0d data=%h/%h last=%b/1", c, up_data_o, ed, up_last_o);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit            pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [DW-1:0] d [2];
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic [DW-1:0] ed;
    logic          ev;
    int            nx = 0;
    d[0] = rnd64();
    d[1] = rnd64();
    @(negedge clk_i);
    ur_mode    = 2;
    up_ready_i = 1'b1;
    bq[1].push_back(mk(d[0], 1'b0));
    bq[1].push_back(mk(d[1], 1'b1));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      #2;
      up_ready_i = pat[c];
      @(negedge clk_i);
      ev = (c >= 1 && c <= 3);
      eg = ev ? 4'b0010 : 4'b0000;
      er = pat[c] ? eg : 4'b0000;
      ed = (c == 1) ? d[0] : d[1];
      if (up_valid_o === 1'b1 && up_ready_i === 1'b1) nx++;
      total++;
      if (grant_o !== eg || up_valid_o !== ev || req_ready_o !== er) begin
        bad++;
        $display("FAIL bp_ctrl c%0d grant=%b/%b valid=%b/%b ready=%b/%b", c, grant_o, eg, up_valid_o, ev, req_ready_o, er);
      end
      if (ev) begin
        total++;
        if (up_data_o !== ed || up_last_o !== (c >= 2)) begin
          bad++;
          $display("FAIL bp_beat c%0d data=%h/%h last=%b", c, up_data_o, ed, up_last_o);
        end
      end
    end
    total++;
    if (nx != 2) begin
      bad++;
      $display("FAIL bp_count transfers=%0d expected=2", nx);
    end
    ur_mode = 0;
  endtask

  task automatic test_overlong();
    logic [DW-1:0] d [20];
    logic [N-1:0]  eg;
    logic          ev;
    logic          el;
    logic          ee;
    int            bi;
    int            ne = 0;
    for (int i = 0; i < 20; i++) d[i] = rnd64();
    @(negedge clk_i);
    for (int i = 0; i < 20; i++) bq[0].push_back(mk(d[i], 1'b0));
    for (int c = 0; c < 24; c++) begin
      @(negedge clk_i);
      ev = (c >= 1 && c <= 16) || (c >= 18 && c <= 21);
      eg = (c >= 1 && c != 17) ? 4'b0001 : 4'b0000;
      el = (c == 16);
      ee = (c == 17);
      bi = (c <= 16) ? c - 1 : c - 2;
      if (err_overlong_o === 1'b1) ne++;
      total++;
      if (grant_o !== eg || up_valid_o !== ev || err_overlong_o !== ee) begin
        bad++;
        $display("FAIL ovl_ctrl c%0d grant=%b/%b valid=%b/%b err=%b/%b", c, grant_o, eg, up_valid_o, ev, err_overlong_o, ee);
      end
      if (ev) begin
        total++;
        if (up_data_o !== d[bi] || up_last_o !== el) begin
          bad++;
          $display("FAIL ovl_beat c%0d data=%h/%h last=%b/%b", c, up_data_o, d[bi], up_last_o, el);
        end
      end
    end
    total++;
    if (ne != 1) begin
      bad++;
      $display("FAIL ovl_err_count pulses=%0d expected=1", ne);
    end
  endtask

  task automatic test_exact_max();
    logic [N-1:0] eg;
    logic         ev;
    apply_reset();
    @(negedge clk_i);
    for (int i = 0; i < MB; i++) bq[2].push_back(mk(DW'(i + 500), i == MB - 1));
    for (int c = 0; c < 19; c++) begin
      @(negedge clk_i);
      ev = (c >= 1 && c <= MB);
      eg = ev ? 4'b0100 : 4'b0000;
      total++;
      if (grant_o !== eg || err_overlong_o !== 1'b0 || (ev && (up_data_o !== DW'(c + 499) || up_last_o !== (c == MB)))) begin
        bad++;
        $display("FAIL max_beat c%0d grant=%b/%b err=%b/0 data=%h last=%b", c, grant_o, eg, err_overlong_o, up_data_o, up_last_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d3 [4];
    logic [DW-1:0] d1;
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    logic          el;
    apply_reset();
    for (int i = 0; i < 4; i++) d3[i] = rnd64();
    d1 = rnd64();
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) bq[3].push_back(mk(d3[i], i == 3));
    @(negedge clk_i);
    @(negedge clk_i);
    total++;
    if (grant_o !== 4'b1000 || up_data_o !== d3[0]) begin
      bad++;
      $display("FAIL rmid_start grant=%b/1000 data=%h/%h", grant_o, up_data_o, d3[0]);
    end
    bq[1].push_back(mk(d1, 1'b1));
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    total++;
    if (grant_o !== '0 || up_valid_o !== 1'b0 || up_last_o !== 1'b0 || req_ready_o !== '0 || err_overlong_o !== 1'b0 || up_data_o !== '0) begin
      bad++;
      $display("FAIL rmid_async grant=%b valid=%b last=%b ready=%b err=%b data=%h (all must be 0)", grant_o, up_valid_o, up_last_o, req_ready_o, err_overlong_o, up_data_o);
    end
    repeat (2) @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (grant_o !== '0 || up_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rmid_release grant=%b valid=%b before first edge, expected 0", grant_o, up_valid_o);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      eg = '0;
      ed = '0;
      el = (c == 0 || c == 4);
      if (c == 0) begin
        eg = 4'b0010;
        ed = d1;
      end else if (c >= 2 && c <= 4) begin
        eg = 4'b1000;
        ed = d3[c-1];
      end
      total++;
      if (grant_o !== eg || up_valid_o !== (eg != '0) || (eg != '0 && (up_data_o !== ed || up_last_o !== el))) begin
        bad++;
        $display("FAIL rmid_order c%0d grant=%b/%b data=%h/%h last=%b/%b", c, grant_o, eg, up_data_o, ed, up_last_o, el);
      end
    end
  endtask

  task automatic test_random();
    int            owner = -1;
    int            ptr = 0;
    int            seg = 0;
    int            exp_err = 0;
    int            err_seen = 0;
    int            len;
    bit            err_exp = 1'b0;
    bit            done = 1'b0;
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic          ev;
    logic          el;
    beat_t         hb;
    beat_t         bt;
    apply_reset();
    @(negedge clk_i);
    for (int k = 0; k < N; k++) begin
      sb_q[k].delete();
      for (int m = 0; m < 6; m++) begin
        len     = $urandom_range(1, 20);
        exp_err += (len - 1) / MB;
        for (int b = 0; b < len; b++) begin
          bt = mk(rnd64(), b == len - 1);
          bq[k].push_back(bt);
          sb_q[k].push_back(bt);
        end
      end
    end
    ur_mode  = 1;
    gap_mode = 1'b1;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk_i);
      eg = '0;
      if (owner >= 0) eg[owner] = 1'b1;
      total++;
      if (grant_o !== eg || err_overlong_o !== err_exp) begin
        bad++;
        $display("FAIL rnd_grant cyc%0d grant=%b/%b err=%b/%b", cyc, grant_o, eg, err_overlong_o, err_exp);
      end
      if (err_overlong_o === 1'b1) err_seen++;
      ev = 1'b0;
      el = 1'b0;
      hb = '0;
      if (owner < 0) begin
        total++;
        if (up_valid_o !== 1'b0 || req_ready_o !== '0) begin
          bad++;
          $display("FAIL rnd_idle cyc%0d valid=%b ready=%b (must be 0)", cyc, up_valid_o, req_ready_o);
        end
      end else begin
        ev = req_valid_i[owner];
        er = up_ready_i ? eg : '0;
        total++;
        if (up_valid_o !== ev || req_ready_o !== er) begin
          bad++;
          $display("FAIL rnd_hs cyc%0d valid=%b/%b ready=%b/%b", cyc, up_valid_o, ev, req_ready_o, er);
        end
        if (ev) begin
          if (sb_q[owner].size() > 0) hb = sb_q[owner][0];
          el = hb.last || (seg == MB - 1);
          total++;
          if (up_data_o !== hb.dat || up_last_o !== el) begin
            bad++;
            $display("FAIL rnd_beat cyc%0d req%0d data=%h/%h last=%b/%b", cyc, owner, up_data_o, hb.dat, up_last_o, el);
          end
        end
      end
      // What the next rising edge should do.
      err_exp = 1'b0;
      if (owner < 0) begin
        for (int i = 0; i < N; i++) begin
          if (owner < 0 && req_valid_i[(ptr + i) % N]) begin
            owner = (ptr + i) % N;
            seg   = 0;
          end
        end
      end else if (ev && up_ready_i) begin
        err_exp = (seg == MB - 1) && !hb.last;
        if (sb_q[owner].size() > 0) void'(sb_q[owner].pop_front());
        seg++;
        if (el) begin
          ptr   = (owner + 1) % N;
          owner = -1;
        end
      end
      done = (owner < 0) && !err_exp;
      for (int k = 0; k < N; k++) if (sb_q[k].size() != 0) done = 1'b0;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL rnd_timeout traffic still pending after 6000 cycles, expected drained");
    end
    total++;
    if (err_seen != exp_err) begin
      bad++;
      $display("FAIL rnd_err_count pulses=%0d expected=%0d", err_seen, exp_err);
    end
    ur_mode  = 0;
    gap_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overlong();
    test_exact_max();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmi64_upstream_arbiter.md
MMI64_UPSTREAM_ARBITER -- requirements
Module: mmi64_upstream_arbiter

Interface
REQ-001 The block SHALL take the parameter N_REQ, default 4, meaning the number of requester ports.
REQ-002 The block SHALL take the parameter DATA_W, default 64, meaning the message beat width in bits.
REQ-003 The block SHALL take the parameter MAX_BEATS, default 16, meaning the maximum number of beats in one granted message.
REQ-004 The block SHALL have the port clk_i, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have the port rst_n_i, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have the port req_valid_i, input, N_REQ bits: per-requester beat valid.
REQ-007 The block SHALL have the port req_data_i, input, N_REQ*DATA_W bits: per-requester beat data; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 The block SHALL have the port req_last_i, input, N_REQ bits: per-requester last-beat flag.
REQ-009 The block SHALL have the port req_ready_o, output, N_REQ bits: per-requester beat accept.
REQ-010 The block SHALL have the port up_valid_o, output, 1 bit: upstream beat valid.
REQ-011 The block SHALL have the port up_data_o, output, DATA_W bits: upstream beat data.
REQ-012 The block SHALL have the port up_last_o, output, 1 bit: upstream last-beat flag.
REQ-013 The block SHALL have the port up_ready_i, input, 1 bit: upstream accept.
REQ-014 The block SHALL have the port grant_o, output, N_REQ bits: one-hot current owner; all zero when idle.
REQ-015 The block SHALL have the port err_overlong_o, output, 1 bit: one-cycle pulse on a truncated message.

Function
REQ-016 A transfer SHALL occur on a rising clk_i edge where valid and ready are both 1 on the same port.
REQ-017 The FSM SHALL have two states, IDLE and BUSY; grant, state, round-robin pointer and beat counter SHALL be registers.
REQ-018 In IDLE, when any req_valid_i bit is 1, the block SHALL grant the first requester with valid=1, searching upward from pointer modulo N_REQ, and SHALL enter BUSY on the next edge.
REQ-019 The arbitration latency SHALL be 1 cycle: no beat SHALL transfer in the IDLE cycle.
REQ-020 In IDLE, up_valid_o, grant_o and req_ready_o SHALL be 0.
REQ-021 In BUSY with owner g, up_valid_o SHALL equal req_valid_i[g], up_data_o SHALL equal requester g's data, and up_last_o SHALL equal req_last_i[g] OR'd with the forced-last term.
REQ-022 In BUSY with owner g, req_ready_o[g] SHALL equal up_ready_i, and all other req_ready_o bits SHALL be 0; this path is combinational.
REQ-023 The grant SHALL be held while the owner deasserts valid mid-message; other requesters SHALL NOT preempt it.
REQ-024 The beat counter SHALL reset to 0 on grant and increment on each upstream transfer; its width SHALL be clog2(MAX_BEATS+1).
REQ-025 The forced-last term SHALL be 1 when counter == MAX_BEATS-1.
REQ-026 On a transfer with up_last_o=1, the block SHALL return to IDLE, clear grant_o, and set pointer = (g+1) mod N_REQ.
REQ-027 If a forced-last transfer occurs with req_last_i[g]=0, err_overlong_o SHALL pulse 1 on the following cycle; the requester's remaining beats SHALL be arbitrated as a new message.
REQ-028 A requester asserting last on beat MAX_BEATS SHALL NOT trigger err_overlong_o.
REQ-029 For N_REQ=1, the block SHALL still pass through IDLE for 1 cycle between messages.

Reset
REQ-030 When rst_n_i=0, the block SHALL clear, asynchronously, state=IDLE, grant_o=0, pointer=0, counter=0 and err_overlong_o=0; up_valid_o and req_ready_o SHALL therefore be 0.
REQ-031 A reset asserted mid-message SHALL abort the message with no further beats accepted; after release, arbitration SHALL restart from requester 0.
REQ-032 The first arbitration decision after reset release SHALL occur no earlier than the first clk_i edge with rst_n_i=1.

Verification
REQ-033 Single requester: req 2 sends 3 beats (A,B,C, last on C), up_ready_i=1 -> grant_o=4'b0100 on cycle 1, up_data_o=A,B,C on cycles 1-3, back to IDLE on cycle 4, no error.
REQ-034 Round-robin: all 4 requesters hold valid with 1-beat messages -> grant order 0,1,2,3,0, each granted message followed by one IDLE cycle.
REQ-035 Backpressure: up_ready_i toggles 1,0,1 during a 2-beat message from req 1 -> req_ready_o[1] follows up_ready_i, up_data_o stays stable while stalled, exactly 2 transfers occur.
REQ-036 Overlong: req 0 sends 20 beats with no last (MAX_BEATS=16) -> up_last_o=1 on beat 16, err_overlong_o pulses once, and the remaining 4 beats go out as a new granted message with a forced last at beat 4 absent.
REQ-037 Reset mid-message: rst_n_i is pulled low during beat 2 of 4 from req 3 -> all outputs go 0 immediately; after release, a pending req 3 and req 1 are granted in order req 1 then req 3.
